// File: rtl/snes_input_arbiter.sv
// Shares the SNES encoder between keyboard, IR and button sources; one word per encoder frame.
// Optional merge mode (dip=10) is built only when SNES_ARB_MERGE_EN is defined.
module snes_input_arbiter #(
  parameter int unsigned HOLD_CYCLES = 20800,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  input  logic       ir_valid,
  input  logic [7:0] ir_data,
  input  logic [7:0] btn_data,
  input  logic [1:0] dip,
  input  logic       enc_ready,
  output logic       enc_load,
  output logic [7:0] enc_data,
  output logic [1:0] grant,
  output logic       busy
);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_KB   = 2'b01;
  localparam logic [1:0] SRC_IR   = 2'b10;
  localparam logic [1:0] SRC_BTN  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARB  = 2'b01,
    ST_LOAD = 2'b10,
    ST_WAIT = 2'b11
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] kb_cnt_r;
  logic [CNT_W-1:0] ir_cnt_r;
  logic [7:0]       kb_word_r;
  logic [7:0]       ir_word_r;
  logic [7:0]       btn_word_r;
  logic [1:0]       rr_ptr_r;
  logic             enc_load_r;
  logic [7:0]       enc_data_r;
  logic [1:0]       grant_r;
  logic             busy_r;

  logic             kb_act_s;
  logic             ir_act_s;
  logic             btn_act_s;
  logic [1:0]       prio_grant_s;
  logic [1:0]       rr_grant_s;
  logic [1:0]       sel_grant_s;
  logic [7:0]       sel_data_s;

  // First active source in the given search order
  function automatic logic [1:0] pick3(
    input logic a0, input logic a1, input logic a2,
    input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2
  );
    logic [1:0] r;
    if (a0) begin
      r = s0;
    end else if (a1) begin
      r = s1;
    end else if (a2) begin
      r = s2;
    end else begin
      r = SRC_NONE;
    end
    return r;
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      SRC_KB:  r = SRC_IR;
      SRC_IR:  r = SRC_BTN;
      SRC_BTN: r = SRC_KB;
      default: r = SRC_KB;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] src_word(
    input logic [1:0] g, input logic [7:0] kb_w, input logic [7:0] ir_w, input logic [7:0] btn_w
  );
    logic [7:0] r;
    case (g)
      SRC_KB:  r = kb_w;
      SRC_IR:  r = ir_w;
      SRC_BTN: r = btn_w;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Keyboard hold stage: a valid pulse (re)loads, otherwise count down and drop the word at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kb_cnt_r  <= CNT_ZERO;
      kb_word_r <= 8'h00;
    end else if (kb_valid) begin
      kb_cnt_r  <= HOLD_LOAD;
      kb_word_r <= kb_data;
    end else if (kb_cnt_r != CNT_ZERO) begin
      kb_cnt_r <= kb_cnt_r - CNT_ONE;
      if (kb_cnt_r == CNT_ONE) begin
        kb_word_r <= 8'h00;
      end
    end
  end

  // IR hold stage, identical behaviour to the keyboard stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_cnt_r  <= CNT_ZERO;
      ir_word_r <= 8'h00;
    end else if (ir_valid) begin
      ir_cnt_r  <= HOLD_LOAD;
      ir_word_r <= ir_data;
    end else if (ir_cnt_r != CNT_ZERO) begin
      ir_cnt_r <= ir_cnt_r - CNT_ONE;
      if (ir_cnt_r == CNT_ONE) begin
        ir_word_r <= 8'h00;
      end
    end
  end

  // Button level register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_word_r <= 8'h00;
    end else begin
      btn_word_r <= btn_data;
    end
  end

  assign kb_act_s  = (kb_cnt_r != CNT_ZERO) && (kb_word_r != 8'h00);
  assign ir_act_s  = (ir_cnt_r != CNT_ZERO) && (ir_word_r != 8'h00);
  assign btn_act_s = (btn_word_r != 8'h00);

  // Fixed priority btn > kb > IR
  always_comb begin
    prio_grant_s = pick3(btn_act_s, kb_act_s, ir_act_s, SRC_BTN, SRC_KB, SRC_IR);
  end

  // Round-robin search beginning at the pointer
  always_comb begin
    rr_grant_s = SRC_NONE;
    case (rr_ptr_r)
      SRC_IR:  rr_grant_s = pick3(ir_act_s, btn_act_s, kb_act_s, SRC_IR, SRC_BTN, SRC_KB);
      SRC_BTN: rr_grant_s = pick3(btn_act_s, kb_act_s, ir_act_s, SRC_BTN, SRC_KB, SRC_IR);
      default: rr_grant_s = pick3(kb_act_s, ir_act_s, btn_act_s, SRC_KB, SRC_IR, SRC_BTN);
    endcase
  end

  // Mode select: produces the word and grant that ARB will register
  always_comb begin
    sel_grant_s = prio_grant_s;
    sel_data_s  = src_word(prio_grant_s, kb_word_r, ir_word_r, btn_word_r);
    case (dip)
      2'b01: begin
        sel_grant_s = rr_grant_s;
        sel_data_s  = src_word(rr_grant_s, kb_word_r, ir_word_r, btn_word_r);
      end
      2'b10: begin
`ifdef SNES_ARB_MERGE_EN
        sel_grant_s = SRC_NONE;
        sel_data_s  = (kb_act_s  ? kb_word_r  : 8'h00) |
                      (ir_act_s  ? ir_word_r  : 8'h00) |
                      (btn_act_s ? btn_word_r : 8'h00);
`else
        sel_grant_s = prio_grant_s;
        sel_data_s  = src_word(prio_grant_s, kb_word_r, ir_word_r, btn_word_r);
`endif
      end
      2'b11: begin
        sel_grant_s = btn_act_s ? SRC_BTN : SRC_NONE;
        sel_data_s  = btn_word_r;
      end
      default: begin
        sel_grant_s = prio_grant_s;
        sel_data_s  = src_word(prio_grant_s, kb_word_r, ir_word_r, btn_word_r);
      end
    endcase
  end

  // Frame sequencer: IDLE -> ARB -> LOAD -> WAIT, all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      enc_load_r <= 1'b0;
      enc_data_r <= 8'h00;
      grant_r    <= SRC_NONE;
      busy_r     <= 1'b0;
      rr_ptr_r   <= SRC_KB;
    end else begin
      case (state_r)
        ST_IDLE: begin
          enc_load_r <= 1'b0;
          if (enc_ready) begin
            state_r <= ST_ARB;
            busy_r  <= 1'b1;
          end
        end
        ST_ARB: begin
          state_r    <= ST_LOAD;
          enc_load_r <= 1'b1;
          enc_data_r <= sel_data_s;
          grant_r    <= sel_grant_s;
          if ((dip == 2'b01) && (rr_grant_s != SRC_NONE)) begin
            rr_ptr_r <= next_src(rr_grant_s);
          end
        end
        ST_LOAD: begin
          enc_load_r <= 1'b0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          enc_load_r <= 1'b0;
          // A fresh frame needs the encoder to drop ready first
          if (!enc_ready) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          enc_load_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign enc_load = enc_load_r;
  assign enc_data = enc_data_r;
  assign grant    = grant_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_snes_input_arbiter.sv
// Bench for snes_input_arbiter: time-stamped source model plus directed literal scenarios.
module tb_snes_input_arbiter;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       kb_valid = 1'b0;
  logic       ir_valid = 1'b0;
  logic       enc_ready = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic [7:0] ir_data = 8'h00;
  logic [7:0] btn_data = 8'h00;
  logic [1:0] dip = 2'b00;
  logic       enc_load;
  logic       busy;
  logic [7:0] enc_data;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_bad = 0;

  snes_input_arbiter #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .kb_valid(kb_valid), .kb_data(kb_data),
    .ir_valid(ir_valid), .ir_data(ir_data),
    .btn_data(btn_data), .dip(dip), .enc_ready(enc_ready),
    .enc_load(enc_load), .enc_data(enc_data), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sources described by time of last capture, frames by start cycle
  int         cyc = 0;
  int         kb_t = -1000;
  int         ir_t = -1000;
  logic [7:0] kb_w = 8'h00;
  logic [7:0] ir_w = 8'h00;
  logic [7:0] btn_w = 8'h00;
  bit         free = 1'b1;
  int         t_start = -100;
  int         m_ptr = 0;
  int         m_g;
  int         m_s;
  int         m_mode;
  bit         m_act[3];
  logic [7:0] m_word[3];
  logic [7:0] m_d;
  logic       exp_load = 1'b0;
  logic       exp_busy = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic [1:0] exp_grant = 2'b00;

  always @(negedge clk) begin
    check("enc_load", 16'(enc_load), 16'(exp_load));
    check("enc_data", 16'(enc_data), 16'(exp_data));
    check("grant", 16'(grant), 16'(exp_grant));
    check("busy", 16'(busy), 16'(exp_busy));
    if (!reset_n) begin
      kb_w = 8'h00; ir_w = 8'h00; btn_w = 8'h00;
      free = 1'b1; t_start = -100; m_ptr = 0;
      exp_load = 1'b0; exp_busy = 1'b0; exp_data = 8'h00; exp_grant = 2'b00;
    end else begin
      m_word[0] = kb_w; m_word[1] = ir_w; m_word[2] = btn_w;
      m_act[0] = (kb_w != 0) && (cyc - kb_t >= 1) && (cyc - kb_t <= H);
      m_act[1] = (ir_w != 0) && (cyc - ir_t >= 1) && (cyc - ir_t <= H);
      m_act[2] = (btn_w != 0);
      exp_load = 1'b0;
      if (cyc == t_start + 1) begin
        m_mode = int'(dip);
`ifndef SNES_ARB_MERGE_EN
        if (m_mode == 2) m_mode = 0;
`endif
        m_g = 0;
        m_d = 8'h00;
        case (m_mode)
          0: m_g = m_act[2] ? 3 : m_act[0] ? 1 : m_act[1] ? 2 : 0;
          1: begin
            for (int k = 0; k < 3; k++) begin
              m_s = (m_ptr + k) % 3;
              if (m_g == 0 && m_act[m_s]) m_g = m_s + 1;
            end
            if (m_g != 0) m_ptr = m_g % 3;
          end
          2: m_g = 0;
          default: m_g = (btn_w != 0) ? 3 : 0;
        endcase
        if (m_mode == 2) begin
          for (int k = 0; k < 3; k++) if (m_act[k]) m_d = m_d | m_word[k];
        end else if (m_g != 0) begin
          m_d = m_word[m_g - 1];
        end
        exp_data = m_d;
        exp_grant = 2'(m_g);
        exp_load = 1'b1;
      end
      if (free && enc_ready) begin
        t_start = cyc;
        free = 1'b0;
      end else if (!free && cyc >= t_start + 3 && !enc_ready) begin
        free = 1'b1;
      end
      exp_busy = !free;
      if (kb_valid) begin kb_w = kb_data; kb_t = cyc; end
      if (ir_valid) begin ir_w = ir_data; ir_t = cyc; end
      btn_w = btn_data;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic k, input logic [7:0] kd, input logic i, input logic [7:0] id);
    kb_valid = k; kb_data = kd; ir_valid = i; ir_data = id;
    tick();
    kb_valid = 1'b0; ir_valid = 1'b0;
  endtask

  task automatic do_frame(input string name, input logic [7:0] ed, input logic [1:0] eg);
    bit got;
    logic [7:0] d;
    logic [1:0] g;
    got = 1'b0; d = 8'h00; g = 2'b00;
    enc_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (enc_load) begin got = 1'b1; d = enc_data; g = grant; end
    end
    check({name, "_load_seen"}, 16'(got), 16'd1);
    check({name, "_data"}, 16'(d), 16'(ed));
    check({name, "_grant"}, 16'(g), 16'(eg));
    enc_ready = 1'b0;
    tick();
    tick();
  endtask

  int loads;

  initial begin
    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      kb_valid = 1'($urandom); kb_data = 8'($urandom);
      ir_valid = 1'($urandom); ir_data = 8'($urandom);
      btn_data = 8'($urandom); dip = 2'($urandom); enc_ready = 1'($urandom);
      tick();
      check("rst_load", 16'(enc_load), 16'd0);
      check("rst_data", 16'(enc_data), 16'd0);
      check("rst_grant", 16'(grant), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
    end
    reset_n = 1'b1; enc_ready = 1'b1; kb_valid = 1'b0; ir_valid = 1'b0;
    btn_data = 8'h00; dip = 2'b00;
    tick();
    check("rel_c1_busy", 16'(busy), 16'd1);
    check("rel_c1_load", 16'(enc_load), 16'd0);
    tick();
    check("rel_c2_load", 16'(enc_load), 16'd1);
    check("rel_c2_data", 16'(enc_data), 16'h00);
    check("rel_c2_grant", 16'(grant), 16'd0);
    enc_ready = 1'b0;
    tick();
    tick();

    // Fixed priority
    btn_data = 8'h01;
    pulse(1'b1, 8'h80, 1'b0, 8'h00);
    do_frame("prio_btn", 8'h01, 2'b11);
    btn_data = 8'h00;
    do_frame("prio_kb", 8'h80, 2'b01);

    // Hold expiry and retrigger
    repeat (10) tick();
    pulse(1'b0, 8'h00, 1'b1, 8'h10);
    do_frame("hold_f1", 8'h10, 2'b10);
    do_frame("hold_f2", 8'h10, 2'b10);
    do_frame("hold_exp", 8'h00, 2'b00);
    pulse(1'b0, 8'h00, 1'b1, 8'h10);
    repeat (7) tick();
    pulse(1'b0, 8'h00, 1'b1, 8'h10);
    do_frame("retrig_f1", 8'h10, 2'b10);
    do_frame("retrig_f2", 8'h10, 2'b10);
    do_frame("retrig_exp", 8'h00, 2'b00);

    // Round-robin
    dip = 2'b01; btn_data = 8'h08;
    pulse(1'b1, 8'h02, 1'b1, 8'h04);
    do_frame("rr_1", 8'h02, 2'b01);
    pulse(1'b1, 8'h02, 1'b1, 8'h04);
    do_frame("rr_2", 8'h04, 2'b10);
    pulse(1'b1, 8'h02, 1'b1, 8'h04);
    do_frame("rr_3", 8'h08, 2'b11);
    pulse(1'b1, 8'h02, 1'b1, 8'h04);
    do_frame("rr_4", 8'h02, 2'b01);

    // Merge
    dip = 2'b10;
    pulse(1'b1, 8'h02, 1'b1, 8'h04);
`ifdef SNES_ARB_MERGE_EN
    do_frame("merge", 8'h0E, 2'b00);
`else
    do_frame("merge", 8'h08, 2'b11);
`endif
    dip = 2'b00; btn_data = 8'h00;

    // Ready held high: one load only, then reset during WAIT
    enc_ready = 1'b1;
    loads = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (enc_load) loads++;
    end
    check("held_ready_loads", 16'(loads), 16'd1);
    check("held_ready_busy", 16'(busy), 16'd1);
    reset_n = 1'b0;
    tick();
    check("wait_rst_busy", 16'(busy), 16'd0);
    check("wait_rst_load", 16'(enc_load), 16'd0);
    reset_n = 1'b1; enc_ready = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      kb_valid = ($urandom_range(0, 9) == 0);
      kb_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      ir_valid = ($urandom_range(0, 9) == 0);
      ir_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 19) == 0) btn_data = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 29) == 0) dip = 2'($urandom);
      if ($urandom_range(0, 3) == 0) enc_ready = ~enc_ready;
      tick();
    end
    kb_valid = 1'b0; ir_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snes_input_arbiter.md
# snes_input_arbiter

Shares the single SNES encoder between the three controller input sources: PS/2 keyboard, IR remote and on-board buttons. Momentary keyboard/IR events are stretched into held button presses. Once per encoder frame, the block selects or merges one 8-bit button word according to the DIP mode and hands it to the encoder with a load handshake. It sits between the input decoders/inverter and `snes_encoder`, replacing the combinational source mux.

## Interface
- `HOLD_CYCLES`, default 20800 — cycles a kb/IR press is held (10 ms at 2.08 MHz); must be ≥1.
- `CNT_W`, default 16 — hold counter width; HOLD_CYCLES < 2^CNT_W.
- `clk` in 1 — system clock (2.08 MHz domain).
- `reset_n` in 1 — reset; synchronous, active-low.
- `kb_valid` in 1 — one-cycle pulse; `kb_data` is valid.
- `kb_data` in 8 — decoded keyboard button word, active-high.
- `ir_valid` in 1 — one-cycle pulse; `ir_data` is valid.
- `ir_data` in 8 — decoded IR button word, active-high.
- `btn_data` in 8 — button level word, already inverted to active-high.
- `dip` in 2 — mode: 00 fixed priority, 01 round-robin, 10 merge, 11 buttons only.
- `enc_ready` in 1 — encoder idle and able to accept a word.
- `enc_load` out 1 — one-cycle load strobe to the encoder.
- `enc_data` out 8 — button word; stable from the `enc_load` cycle until the next load.
- `grant` out 2 — source of the last word: 00 none/merge, 01 kb, 10 IR, 11 btn.
- `busy` out 1 — high in ARB, LOAD and WAIT.

## Operation
- **Hold stages (kb, IR, independent):**
  - On `*_valid`, capture the data and load the counter with HOLD_CYCLES.
  - Otherwise, a nonzero counter decrements by 1 per cycle. When it reaches 0, the held word clears to 0.
  - A valid pulse arriving while the counter is nonzero retriggers: new data, counter reloads.
  - A source is active when its counter is nonzero and its held word is nonzero.
- **Button stage:** `btn_data` is registered once. The stage is active when the registered word is nonzero.
- **FSM:**
  - IDLE: leaves to ARB when `enc_ready`=1.
  - ARB: samples `dip` and the active flags, computes the word and grant, then goes to LOAD.
  - LOAD: `enc_load`=1 for exactly one cycle, then WAIT.
  - WAIT: stays until `enc_ready`=0, then IDLE.
- **Modes:**
  - 00: priority is btn > kb > IR.
  - 01: round-robin in the order kb→IR→btn, starting after the last granted source. Inactive sources are skipped. The pointer updates only on a nonzero grant.
  - 10: `enc_data` = OR of all active words; `grant`=00.
  - 11: registered button word only; `grant`=11 if nonzero, else 00.
- **No active source:** `enc_data`=0 and `grant`=00. A load is still issued, so the encoder transmits "all released".

## Timing
- **Reset values:** `enc_load`=0, `enc_data`=0, `grant`=00, `busy`=0; state IDLE; counters 0; held words 0; round-robin pointer = kb.
- **Sampling:** `enc_ready` is sampled high in IDLE at cycle t. ARB runs at t+1 and `enc_load` pulses at t+2. `enc_data` and `grant` update in the same cycle as `enc_load`.
- **Capture latency:** `*_valid` at cycle t makes the source active at t+1, i.e. eligible for an ARB at t+1 or later. `btn_data` becomes eligible 1 cycle after it changes.
- **Retrigger vs. expiry:** a valid pulse in the same cycle the counter would reach 0 wins; the counter reloads.
- **DIP sampling:** `dip` is sampled only in ARB. A change mid-frame takes effect at the next ARB.
- **Encoder ready timing:** if `enc_ready` stays high, WAIT holds indefinitely. No new load is issued until the encoder drops and re-raises ready.
- **Reset mid-operation:** any state → IDLE on the next edge; a LOAD in flight is aborted (`enc_load`=0).

## Configuration
- **`SNES_ARB_MERGE_EN` defined:** dip=10 selects merge mode as described above.
- **Undefined:** the merge OR logic is not built, and dip=10 behaves exactly as dip=00 (fixed priority, grant reports the chosen source).

## Test plan
- **Reset:** hold `reset_n`=0 with all inputs toggling → all outputs 0. After release with `enc_ready`=1 → `enc_load` at cycle 2 after release with `enc_data`=0x00, `grant`=00.
- **Priority:** dip=00, `btn_data`=0x01, kb pulse 0x80 → `enc_data`=0x01, `grant`=11. Release buttons, next frame → 0x80, `grant`=01.
- **Hold expiry:** HOLD_CYCLES=8, IR pulse 0x10 → frames within 8 cycles send 0x10; the first ARB after expiry sends 0x00. A retrigger at the expiry cycle keeps 0x10 for 8 more cycles.
- **Round-robin:** dip=01, kb=0x02, IR=0x04, btn=0x08 all active → grants 01, 10, 11, 01 on successive frames.
- **Merge:** dip=10, same stimulus as round-robin → `enc_data`=0x0E, `grant`=00 with the macro. Without the macro → 0x08, `grant`=11.
- **Handshake/reset:** `enc_ready` held high after a load → exactly one `enc_load`. Assert `reset_n`=0 during WAIT → IDLE next cycle, `busy`=0.
